mdu_sequencer: RTL and testbench



---
 rtl/mdu_sequencer_pkg.sv | 29 ++
 rtl/mdu_sequencer_if.sv | 20 ++
 rtl/mdu_sequencer_step.sv | 26 ++
 rtl/mdu_sequencer.sv | 98 +++++++++
 tb/tb_mdu_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mdu_sequencer_pkg.sv
// mdu_pkg: op codes, FSM states and helpers shared by the multiply/MAC sequencer and the main controller.
// MDU_RADIX4_EN selects two multiplier bits per CALC cycle instead of one.
package mdu_pkg;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = OP_MULT,
    MDU_MULTU = OP_MULTU,
    MDU_MUL   = OP_MUL,
    MDU_MADD  = OP_MADD,
    MDU_MSUB  = OP_MSUB
  } mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
`ifdef MDU_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif
  function automatic logic op_is_signed(input logic [2:0] op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB};
  endfunction
  function automatic logic op_is_valid(input logic [2:0] op);
    return op inside {[OP_MULT:OP_MSUB]};
  endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: controller-side request, HI/LO direct-write and result signals of the multiply/MAC unit.
interface mdu_sequencer_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       HiLoWrite;
  logic [WIDTH-1:0] HiIn;
  logic [WIDTH-1:0] LoIn;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] MulResult;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master (output Start, Op, A, B, HiLoWrite, HiIn, LoIn, Flush,
                  input  Busy, Done, MulResult, HI, LO);
  modport slave  (input  Start, Op, A, B, HiLoWrite, HiIn, LoIn, Flush,
                  output Busy, Done, MulResult, HI, LO);
endinterface

// File: rtl/mdu_sequencer_step.sv
// mdu_step: one shift-add iteration; the running sum sits in the upper half and shifts right as multiplier bits retire.
// MDU_RADIX4_EN retires two bits (add 0/1/2/3 x multiplicand), otherwise one bit.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0]    acc,
  input  logic [WIDTH-1:0]      mcand,
  input  logic [RADIX_BITS-1:0] bits,
  output logic [2*WIDTH-1:0]    acc_next
);
`ifdef MDU_RADIX4_EN
  logic [WIDTH+1:0] sum;
  always_comb begin
    sum = {2'b00, acc[2*WIDTH-1:WIDTH]} + (bits[0] ? {2'b00, mcand} : '0) + (bits[1] ? {1'b0, mcand, 1'b0} : '0);
    acc_next = {sum, acc[WIDTH-1:2]};
  end
`else
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bits[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end
`endif
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/MUL/MADD/MSUB sequencer owning HI/LO; stalls the pipeline via Busy.
// MDU_RADIX4_EN halves the CALC phase by retiring two multiplier bits per cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic Clk,
  input logic Rst_n,
  mdu_sequencer_if.slave bus
);
  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(STEPS);
  state_t             state;
  mdu_op_t            op;
  logic [CW-1:0]      count;
  logic               neg, busy, done, sgn, last;
  logic [WIDTH-1:0]   mcand, mplier, hi, lo, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, step;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .bits     (mplier[RADIX_BITS-1:0]),
    .acc_next (step)
  );
  always_comb begin
    sgn   = op_is_signed(bus.Op);
    abs_a = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    last  = count == CW'(STEPS - 1);
  end
  // The sign fix-up folds into the last CALC step, so acc holds the signed product throughout FINISH.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      op     <= MDU_NOP;
      count  <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (bus.Flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start && op_is_valid(bus.Op)) begin
            op     <= mdu_op_t'(bus.Op);
            neg    <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            mcand  <= abs_a;
            mplier <= abs_b;
            acc    <= '0;
            count  <= '0;
            state  <= S_CALC;
            busy   <= 1'b1;
          end else if (!bus.Start) begin
            if (bus.HiLoWrite[1]) hi <= bus.HiIn;
            if (bus.HiLoWrite[0]) lo <= bus.LoIn;
          end
        end
        S_CALC: begin
          acc    <= (last && neg) ? -step : step;
          mplier <= mplier >> RADIX_BITS;
          count  <= count + CW'(1);
          if (last) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end
        end
        S_FINISH: begin
          case (op)
            MDU_MULT, MDU_MULTU: {hi, lo} <= acc;
            MDU_MADD:            {hi, lo} <= {hi, lo} + acc;
            MDU_MSUB:            {hi, lo} <= {hi, lo} - acc;
            default: ;
          endcase
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign bus.Busy      = busy;
  assign bus.Done      = done & ~bus.Flush;
  assign bus.MulResult = acc[WIDTH-1:0];
  assign bus.HI        = hi;
  assign bus.LO        = lo;
  start_while_busy: assert property (@(posedge Clk) disable iff (!Rst_n) !(bus.Start && busy))
    else $error("mdu_sequencer: Start issued while busy");
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors; expected HI/LO/MulResult and Done timing are queued and checked by a monitor on Done.
module tb_mdu_sequencer;
  import mdu_pkg::*;
  localparam int W = 32;
  localparam int STEPS = W / RADIX_BITS;
  typedef struct {
    logic        chk_mul;
    logic [31:0] mul;
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_edge;
  } exp_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   edges = 0;
  exp_t sb[$];
  always #5 Clk = ~Clk;
  always @(posedge Clk) edges <= edges + 1;
  mdu_sequencer_if #(.WIDTH(W)) bus ();
  mdu_sequencer #(.WIDTH(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (!bus.Busy) return;
    end
    check("idle_timeout", 32'(bus.Busy), 32'd0);
  endtask
  // Called at a negedge; Start is accepted at the following posedge (cycle 0).
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic chk_mul, input logic [31:0] mul, input logic [31:0] hi, input logic [31:0] lo);
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    sb.push_back('{chk_mul, mul, hi, lo, edges + STEPS});
    wait_idle();
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && bus.Done) begin
        if (sb.size() == 0) check("unexpected_done", 32'(bus.Done), 32'd0);
        else begin
          e = sb.pop_front();
          check("done_cycle", 32'(edges), 32'(e.done_edge));
          check("busy_in_finish", 32'(bus.Busy), 32'd1);
          if (e.chk_mul) check("mul_result", bus.MulResult, e.mul);
          @(negedge Clk);
          check("hi", bus.HI, e.hi);
          check("lo", bus.LO, e.lo);
          check("busy_after", 32'(bus.Busy), 32'd0);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    bus.Start = 1'b0;
    bus.Op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    bus.HiLoWrite = 2'b00;
    bus.HiIn = '0;
    bus.LoIn = '0;
    bus.Flush = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_lo", bus.LO, 32'd0);
    check("reset_mulresult", bus.MulResult, 32'd0);
    run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'hFFFFFFFE, 32'h00000001);
    run(OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'd0, 32'h40000000, 32'h00000000);
    run(OP_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run(OP_MULTU, 32'h80000000, 32'd2,        1'b0, 32'd0, 32'h00000001, 32'h00000000);
    bus.HiLoWrite = 2'b11;
    bus.HiIn = 32'd0;
    bus.LoIn = 32'd10;
    @(posedge Clk);
    #1 bus.HiLoWrite = 2'b00;
    @(negedge Clk);
    check("mthi", bus.HI, 32'd0);
    check("mtlo", bus.LO, 32'd10);
    run(OP_MADD, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 32'd16);
    run(OP_MSUB, 32'd4, 32'd5, 1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFC);
    run(OP_MUL,  32'd6, 32'd7, 1'b1, 32'd42, 32'hFFFFFFFF, 32'hFFFFFFFC);
    run(OP_MUL,  32'hFFFFFFFE, 32'd5, 1'b1, 32'hFFFFFFF6, 32'hFFFFFFFF, 32'hFFFFFFFC);
    run(OP_MADD, 32'hFFFFFFFE, 32'd3, 1'b0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF6);
    bus.Op = 3'd6;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    @(negedge Clk);
    check("invalid_op_busy", 32'(bus.Busy), 32'd0);
    bus.Op = OP_MULT;
    bus.A = 32'd5;
    bus.B = 32'd5;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    bus.HiLoWrite = 2'b11;
    bus.HiIn = 32'h1234;
    bus.LoIn = 32'h5678;
    @(posedge Clk);
    #1 bus.HiLoWrite = 2'b00;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    bus.Flush = 1'b1;
    @(posedge Clk);
    #1 bus.Flush = 1'b0;
    check("flush_busy", 32'(bus.Busy), 32'd0);
    repeat (40) @(negedge Clk);
    check("flush_hi", bus.HI, 32'hFFFFFFFF);
    check("flush_lo", bus.LO, 32'hFFFFFFF6);
    bus.Op = OP_MULTU;
    bus.A = 32'd2;
    bus.B = 32'd3;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (STEPS) @(posedge Clk);
    #1 bus.Flush = 1'b1;
    #1 check("finish_flush_busy", 32'(bus.Busy), 32'd1);
    check("finish_flush_done", 32'(bus.Done), 32'd0);
    @(posedge Clk);
    #1 bus.Flush = 1'b0;
    check("finish_flush_idle", 32'(bus.Busy), 32'd0);
    @(negedge Clk);
    check("finish_flush_hi", bus.HI, 32'hFFFFFFFF);
    check("finish_flush_lo", bus.LO, 32'hFFFFFFF6);
    bus.Op = OP_MULTU;
    bus.A = 32'hFFFFFFFF;
    bus.B = 32'hFFFFFFFF;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    check("midrst_hi", bus.HI, 32'd0);
    check("midrst_lo", bus.LO, 32'd0);
    check("midrst_mulresult", bus.MulResult, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    run(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 32'd1);
    repeat (2) @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
